// File: rtl/mem_port_arbiter.sv
// Two-channel (fetch / data) to single memory-port arbiter with registered outputs and a response watchdog.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between channels instead of favouring dmem.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        error
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_s;
   logic [15:0] wdog_r;
   logic        ireq_s;
   logic        dreq_s;
   logic        grant_d_s;
   logic [31:0] mem_addr_r;
   logic [3:0]  mem_rmask_r;
   logic [3:0]  mem_wmask_r;
   logic [31:0] mem_wdata_r;
   logic [31:0] imem_rdata_r;
   logic [31:0] dmem_rdata_r;
   logic        imem_resp_r;
   logic        dmem_resp_r;
   logic        error_r;

   assign ireq_s = (imem_rmask != 4'h0);
   assign dreq_s = ((dmem_rmask | dmem_wmask) != 4'h0);

`ifdef ARB_ROUND_ROBIN_EN
   logic ptr_r;  // channel served most recently (1 = dmem)

   // Tie-break pointer: remembers the last granted channel
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= 1'b1;
      end else if (state_r == ST_IDLE && (ireq_s || dreq_s)) begin
         ptr_r <= grant_d_s;
      end
   end

   // Winner selection: a tie goes to the channel not served last
   always_comb begin
      grant_d_s = 1'b0;
      if (ireq_s && dreq_s) begin
         grant_d_s = ~ptr_r;
      end else begin
         grant_d_s = dreq_s;
      end
   end
`else
   // Winner selection: dmem has fixed priority
   always_comb begin
      grant_d_s = dreq_s;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; DONE never grants because the served channel still shows its request
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ireq_s || dreq_s) begin
               state_s = grant_d_s ? ST_BUSY_D : ST_BUSY_I;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_resp) begin
               state_s = ST_DONE;
            end else begin
               state_s = state_r;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Memory-port, response, watchdog and error registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr_r   <= 32'h0;
         mem_rmask_r  <= 4'h0;
         mem_wmask_r  <= 4'h0;
         mem_wdata_r  <= 32'h0;
         imem_rdata_r <= 32'h0;
         dmem_rdata_r <= 32'h0;
         imem_resp_r  <= 1'b0;
         dmem_resp_r  <= 1'b0;
         error_r      <= 1'b0;
         wdog_r       <= 16'h0;
      end else begin
         imem_resp_r <= 1'b0;
         dmem_resp_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               wdog_r <= 16'h0;
               if (mem_resp) begin
                  error_r <= 1'b1;
               end
               if (ireq_s || dreq_s) begin
                  if (grant_d_s) begin
                     mem_addr_r  <= dmem_addr;
                     mem_rmask_r <= dmem_rmask;
                     mem_wmask_r <= dmem_wmask;
                     mem_wdata_r <= dmem_wdata;
                  end else begin
                     mem_addr_r  <= imem_addr;
                     mem_rmask_r <= imem_rmask;
                     mem_wmask_r <= 4'h0;
                     mem_wdata_r <= 32'h0;
                  end
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               if (mem_resp) begin
                  mem_rmask_r <= 4'h0;
                  mem_wmask_r <= 4'h0;
                  if (state_r == ST_BUSY_I) begin
                     imem_rdata_r <= mem_rdata;
                     imem_resp_r  <= 1'b1;
                  end else begin
                     dmem_rdata_r <= mem_rdata;
                     dmem_resp_r  <= 1'b1;
                  end
               end else begin
                  // Error fires on the edge the counter lands on TIMEOUT; waiting continues
                  if (wdog_r < TO_MAX) begin
                     wdog_r <= wdog_r + 16'd1;
                  end
                  if (wdog_r == TO_LAST) begin
                     error_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (mem_resp) begin
                  error_r <= 1'b1;
               end
            end
            default: begin
               error_r <= 1'b1;
            end
         endcase
      end
   end

   assign mem_addr   = mem_addr_r;
   assign mem_rmask  = mem_rmask_r;
   assign mem_wmask  = mem_wmask_r;
   assign mem_wdata  = mem_wdata_r;
   assign imem_rdata = imem_rdata_r;
   assign dmem_rdata = dmem_rdata_r;
   assign imem_resp  = imem_resp_r;
   assign dmem_resp  = dmem_resp_r;
   assign error      = error_r;

endmodule
